// File: rtl/wired_wb_slot_sched.sv
// Writeback slot scheduler for the 2-bank CDB: books future CDB slots for
// fixed-latency units and reports the current-cycle booking per bank.
module wired_wb_slot_sched #(
  parameter  int REQ_CNT    = 4,
  parameter  int MAX_LAT    = 8,
  parameter  int STARVE_LIM = 3,
  localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic [REQ_CNT-1:0]              req_valid_i,
  input  logic [REQ_CNT-1:0][LAT_W-1:0]   req_lat_i,
  input  logic [REQ_CNT-1:0]              req_bank_i,
  output logic [REQ_CNT-1:0]              grant_o,
  output logic [1:0]                      wb_busy_o,
  output logic                            err_o
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  logic [1:0][MAX_LAT-1:0]        s_q, s_d;
  logic [REQ_CNT-1:0][CNT_W-1:0]  c_q, c_d;
  logic                           err_q, err_d;

  // Extended table: the extra top bit is the empty slot shifting in at MAX_LAT.
  logic [1:0][MAX_LAT:0]          s_ext_s;
  logic [1:0][MAX_LAT:0]          claim_s;
  logic [REQ_CNT-1:0]             legal_s;
  logic [REQ_CNT-1:0]             urgent_s;
  logic [REQ_CNT-1:0]             free_s;
  logic [REQ_CNT-1:0]             grant_s;
  logic                           take_s;

  // Extend the reservation table with an always-free top slot.
  always_comb begin
    s_ext_s = {2{{(MAX_LAT + 1){1'b0}}}};
    for (int b = 0; b < 2; b++) begin
      s_ext_s[b] = {1'b0, s_q[b]};
    end
  end

  // Per-requester legality, urgency and slot-free status.
  always_comb begin
    legal_s  = {REQ_CNT{1'b0}};
    urgent_s = {REQ_CNT{1'b0}};
    free_s   = {REQ_CNT{1'b0}};
    for (int i = 0; i < REQ_CNT; i++) begin
      legal_s[i]  = (req_lat_i[i] != {LAT_W{1'b0}}) &&
                    (req_lat_i[i] <= LAT_W'(MAX_LAT));
      urgent_s[i] = (c_q[i] == CNT_W'(STARVE_LIM));
      free_s[i]   = legal_s[i] && !s_ext_s[req_bank_i[i]][req_lat_i[i]];
    end
  end

  // Two-pass priority grant: urgent requesters first, then the rest, each
  // pass in ascending index; a claimed (bank, L) blocks later requesters.
  always_comb begin
    claim_s = {2{{(MAX_LAT + 1){1'b0}}}};
    grant_s = {REQ_CNT{1'b0}};
    take_s  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < REQ_CNT; i++) begin
        take_s = !flush_i && req_valid_i[i] && legal_s[i] && free_s[i] &&
                 (urgent_s[i] == (p == 0)) &&
                 !claim_s[req_bank_i[i]][req_lat_i[i]];
        grant_s[i] = grant_s[i] | take_s;
        claim_s[req_bank_i[i]][req_lat_i[i]] =
          claim_s[req_bank_i[i]][req_lat_i[i]] | take_s;
      end
    end
  end

  // Shift the table down one slot and merge this cycle's bookings.
  always_comb begin
    s_d = {2{{MAX_LAT{1'b0}}}};
    if (flush_i) begin
      s_d = {2{{MAX_LAT{1'b0}}}};
    end else begin
      for (int b = 0; b < 2; b++) begin
        s_d[b] = s_ext_s[b][MAX_LAT:1] | claim_s[b][MAX_LAT:1];
      end
    end
  end

  // Starvation counters and sticky illegal-latency flag.
  always_comb begin
    c_d = {REQ_CNT{{CNT_W{1'b0}}}};
    for (int i = 0; i < REQ_CNT; i++) begin
      if (flush_i || !req_valid_i[i] || grant_s[i]) begin
        c_d[i] = {CNT_W{1'b0}};
      end else if (!legal_s[i] || urgent_s[i]) begin
        // Illegal requests leave the counter alone; urgent ones saturate.
        c_d[i] = c_q[i];
      end else begin
        c_d[i] = c_q[i] + CNT_W'(1);
      end
    end
    err_d = err_q | (|(req_valid_i & ~legal_s));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= {2{{MAX_LAT{1'b0}}}};
      c_q   <= {REQ_CNT{{CNT_W{1'b0}}}};
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      err_q <= err_d;
    end
  end

  assign grant_o   = grant_s;
  assign wb_busy_o = {s_q[1][0], s_q[0][0]};
  assign err_o     = err_q;

endmodule

// File: tb/tb_wired_wb_slot_sched.sv
// Table-driven bench for wired_wb_slot_sched: one record per clock cycle with
// hand-computed grant, busy and error expectations.
module tb_wired_wb_slot_sched;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic [3:0]  req_valid_i;
  logic [3:0][3:0] req_lat_i;
  logic [3:0]  req_bank_i;
  logic [3:0]  grant_o;
  logic [1:0]  wb_busy_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic [3:0]  valid;
    logic [15:0] lat;
    logic [3:0]  bank;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  wired_wb_slot_sched #(.REQ_CNT(4), .MAX_LAT(8), .STARVE_LIM(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_lat_i   (req_lat_i),
    .req_bank_i  (req_bank_i),
    .grant_o     (grant_o),
    .wb_busy_o   (wb_busy_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic f, input logic [3:0] v,
                              input logic [15:0] l, input logic [3:0] b,
                              input logic [3:0] g, input logic [1:0] bz,
                              input logic e);
    vec_t x;
    x.rst_n = r; x.flush = f; x.valid = v; x.lat = l; x.bank = b;
    x.exp_grant = g; x.exp_busy = bz; x.exp_err = e;
    vecs.push_back(x);
  endfunction

  function automatic void idle(input int n, input logic [1:0] bz, input logic e);
    for (int k = 0; k < n; k++) add(1'b1, 1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, bz, e);
  endfunction

  task automatic chk(input string name, input int row, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b want %b", name, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs at the falling edge, then advance.
  task automatic apply(input vec_t v, input int row);
    rst_n       = v.rst_n;
    flush_i     = v.flush;
    req_valid_i = v.valid;
    req_lat_i   = v.lat;
    req_bank_i  = v.bank;
    @(negedge clk);
    chk("grant", row, grant_o, v.exp_grant);
    chk("busy", row, {2'b00, wb_busy_o}, {2'b00, v.exp_busy});
    chk("err", row, {3'b000, err_o}, {3'b000, v.exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 4'b0000;
    req_lat_i = 16'h0000; req_bank_i = 4'b0000;

    // Reset state
    idle(1, 2'b00, 1'b0);
    // Single grant, L=3 bank 0: busy only at t=3
    add(1'b1, 1'b0, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 2'b00, 1'b0);
    idle(2, 2'b00, 1'b0); idle(1, 2'b01, 1'b0); idle(1, 2'b00, 1'b0);
    // Same-slot conflict on bank 1, req2 retries with L=1 and is still blocked
    add(1'b1, 1'b0, 4'b0101, 16'h0202, 4'b0101, 4'b0001, 2'b00, 1'b0);
    add(1'b1, 1'b0, 4'b0100, 16'h0100, 4'b0100, 4'b0000, 2'b00, 1'b0);
    idle(1, 2'b10, 1'b0); idle(1, 2'b00, 1'b0);
    // Different banks never conflict
    add(1'b1, 1'b0, 4'b0101, 16'h0202, 4'b0001, 4'b0101, 2'b00, 1'b0);
    idle(1, 2'b00, 1'b0); idle(1, 2'b11, 1'b0); idle(1, 2'b00, 1'b0);
    // Starvation promotion at L=MAX_LAT
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 4'b0011, 16'h0088, 4'b0000, 4'b0001, 2'b00, 1'b0);
    add(1'b1, 1'b0, 4'b0011, 16'h0088, 4'b0000, 4'b0010, 2'b00, 1'b0);
    add(1'b1, 1'b0, 4'b0011, 16'h0088, 4'b0000, 4'b0001, 2'b00, 1'b0);
    idle(3, 2'b00, 1'b0); idle(5, 2'b01, 1'b0); idle(1, 2'b00, 1'b0);
    // Table boundary: L=8 then L=7 same bank
    add(1'b1, 1'b0, 4'b0001, 16'h0008, 4'b0000, 4'b0001, 2'b00, 1'b0);
    add(1'b1, 1'b0, 4'b0010, 16'h0070, 4'b0000, 4'b0000, 2'b00, 1'b0);
    idle(6, 2'b00, 1'b0); idle(1, 2'b01, 1'b0); idle(1, 2'b00, 1'b0);
    // Flush discards L=2 and L=5 bookings, forces grant low
    add(1'b1, 1'b0, 4'b0011, 16'h0052, 4'b0000, 4'b0011, 2'b00, 1'b0);
    add(1'b1, 1'b1, 4'b1000, 16'h3000, 4'b0000, 4'b0000, 2'b00, 1'b0);
    idle(5, 2'b00, 1'b0);
    // Flush clears starvation counters: req0 wins again after flush
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 4'b0011, 16'h0088, 4'b0000, 4'b0001, 2'b00, 1'b0);
    add(1'b1, 1'b1, 4'b0011, 16'h0088, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add(1'b1, 1'b0, 4'b0011, 16'h0088, 4'b0000, 4'b0001, 2'b00, 1'b0);
    idle(7, 2'b00, 1'b0); idle(1, 2'b01, 1'b0); idle(1, 2'b00, 1'b0);
    // Illegal L=0, sticky err, cleared by reset
    add(1'b1, 1'b0, 4'b0010, 16'h0000, 4'b0000, 4'b0000, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 4'b0010, 16'h0000, 4'b0000, 4'b0000, 2'b00, 1'b1);
    add(1'b0, 1'b0, 4'b0010, 16'h0000, 4'b0000, 4'b0000, 2'b00, 1'b1);
    idle(1, 2'b00, 1'b0);
    // Illegal L=9; flush does not clear err
    add(1'b1, 1'b0, 4'b0001, 16'h0009, 4'b0000, 4'b0000, 2'b00, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 2'b00, 1'b1);
    idle(1, 2'b00, 1'b1);
    // Reset mid-operation discards a pending booking
    add(1'b1, 1'b0, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 2'b00, 1'b1);
    add(1'b0, 1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 2'b00, 1'b1);
    idle(3, 2'b00, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: L=1 on bank 1 shows busy the very next cycle, once.
    h.rst_n = 1'b1; h.flush = 1'b0; h.valid = 4'b1000; h.lat = 16'h1000;
    h.bank = 4'b1000; h.exp_grant = 4'b1000; h.exp_busy = 2'b00; h.exp_err = 1'b0;
    apply(h, 1000);
    h.valid = 4'b0000; h.lat = 16'h0000; h.bank = 4'b0000; h.exp_grant = 4'b0000;
    h.exp_busy = 2'b10;
    apply(h, 1001);
    h.exp_busy = 2'b00;
    apply(h, 1002);

    // Hand sequence: L=1 and L=2 on bank 0 from req2/req3 both granted,
    // then busy on two consecutive cycles.
    h.valid = 4'b1100; h.lat = 16'h2100; h.bank = 4'b0000; h.exp_grant = 4'b1100;
    h.exp_busy = 2'b00;
    apply(h, 1003);
    h.valid = 4'b0000; h.lat = 16'h0000; h.exp_grant = 4'b0000; h.exp_busy = 2'b01;
    apply(h, 1004);
    apply(h, 1005);
    h.exp_busy = 2'b00;
    apply(h, 1006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wired_wb_slot_sched.md
# wired_wb_slot_sched

Writeback slot scheduler for the 2-bank CDB. Fixed-latency execution units request a CDB bank slot L cycles ahead at issue time. The scheduler grants a request only if that future slot is free, so fixed-latency results never lose CDB arbitration. It keeps one reservation shift register per ROB bank and exports the current-cycle booking, so variable-latency units (LSU, divider) know when a bank's CDB write port is free for them.

## Interface
Parameters:
- REQ_CNT, 4, number of fixed-latency requesters; index 0 has highest base priority.
- MAX_LAT, 8, largest legal writeback latency in cycles (≥2).
- STARVE_LIM, 3, consecutive denials after which a requester is promoted to urgent priority.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush; clears all reservations.
- req_valid_i  in  [REQ_CNT]  requester i wants a slot this cycle.
- req_lat_i  in  [REQ_CNT][$clog2(MAX_LAT+1)]  latency L; result appears on the CDB in cycle t+L.
- req_bank_i  in  [REQ_CNT]  target bank (= wid[0] of the instruction).
- grant_o  out  [REQ_CNT]  combinational grant; the slot is booked iff set.
- wb_busy_o  out  [2]  bank b has a fixed-latency writeback booked in the current cycle.
- err_o  out  1  sticky; set when a valid request carries an illegal L.

## Operation
- State:
  - Reservation table s[b][k], b∈{0,1}, k∈0..MAX_LAT-1. Bit k set means bank b is booked for cycle t+k.
  - Per-requester starvation counter c[i], saturating at STARVE_LIM.
  - Sticky err.
- Legality: L is legal iff 1 ≤ L ≤ MAX_LAT.
  - Illegal requests are never granted, do not touch c[i], and set err (sticky until reset).
- Slot free check for (b, L):
  - L < MAX_LAT: free = !s[b][L].
  - L = MAX_LAT: always free, because the slot shifts in empty.
- Priority order, evaluated per cycle:
  - First, urgent requesters (c[i] == STARVE_LIM), in ascending index.
  - Then non-urgent requesters, in ascending index.
- Grant rule: a requester is granted if it is valid, legal, and its slot is free and not already claimed this cycle by a requester earlier in the priority order.
  - Requesters with a different bank or a different L never conflict.
- Table update, every cycle:
  - s_next[b][k] = s[b][k+1] | book[b][k+1], where s[b][MAX_LAT] = 0 and book[b][L] = OR over granted requesters with (bank, L) = (b, L).
  - A grant with L=1 therefore sets s[b][0] next cycle; wb_busy_o[b] = s[b][0].
- Starvation counter, every cycle:
  - If valid, legal and not granted, c[i] increments (saturating).
  - If granted or not valid, c[i] clears to 0.
- Flush:
  - In the flush_i cycle, grant_o is forced to 0.
  - Next cycle, s, book and every c[i] are 0.
  - err is not cleared by flush.
- Requesters hold req_valid/L/bank until granted, or drop the request on flush. The scheduler stores nothing per request beyond c[i].

## Timing
- Reset: s = 0, c = 0, err = 0. Outputs after reset: wb_busy_o = 0, err_o = 0; grant_o is combinational (0 when no valid request).
- Grant latency is 0 cycles (same cycle as the request). A booking affects the free check from the next cycle.
- A grant at t with L sets wb_busy_o[b] high in exactly cycle t+L, for one cycle only (unless it is rebooked).
- Booking and free check in the same cycle: the free check uses the current s, which the registered update has not yet changed. A slot booked at t cannot be granted again at t+1 with L' = L−1.
- A reset asserted mid-operation discards all bookings. flush_i and rst_n are synchronous; rst_n dominates.

## Test plan
- Single grant:
  - Stimulus: req0 valid, L=3, bank 0 at t=0.
  - Required: grant_o=0001 at t=0; wb_busy_o=01 only at t=3.
- Same-slot conflict:
  - Stimulus: req0 and req2 both L=2, bank 1 at t=0. req2 retries at t=1 with L=1.
  - Required: only req0 granted at t=0. req2 is denied at t=1 because bank 1 slot t+2 is taken; wb_busy_o=10 at t=2. Repeat with bank differing between the two: both granted.
- Starvation promotion (STARVE_LIM=3):
  - Stimulus: req0 and req1 request L=MAX_LAT, bank 0 every cycle.
  - Required: req0 wins t=0..2. c[1] reaches 3 at t=3, so req1 is granted at t=3. Then c[1]=0.
- Table boundary:
  - Stimulus: grant L=MAX_LAT at t=0, then a request with L=MAX_LAT−1, same bank, at t=1.
  - Required: denied at t=1. wb_busy_o set only at t=8.
- Flush:
  - Stimulus: grants with L=2, L=5 at t=0; flush_i at t=1 with req3 valid.
  - Required: grant_o=0 at t=1; wb_busy_o stays 0 thereafter; c all 0 at t=2.
- Illegal latency:
  - Stimulus: req1 with L=0 at t=0; reset at t=4.
  - Required: never granted; err_o=1 from t=1, cleared at t=5.
